// File: rtl/yaw_integrator.sv
// yaw_integrator: calibrates the gyro zero-rate offset, then integrates scaled yaw rate into a wrapping heading.
// Guardrail fusion is compiled in only when GUARDRAIL_FUSION_EN is defined.
module yaw_integrator #(
    parameter int CAL_SMPLS_LOG2 = 11,
    parameter int SCALE_NUM      = 31,
    parameter int SCALE_SHIFT    = 5,
    parameter int INT_W          = 27,
    parameter int HEAD_W         = 12,
    parameter int FUSION_MAG     = 12288
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     strt_cal,
    input  logic                     zero_hdg,
    input  logic                     vld,
    input  logic signed [15:0]       yaw_rt,
    input  logic                     moving,
    input  logic                     lftIR,
    input  logic                     rghtIR,
    output logic                     cal_done,
    output logic                     cal_busy,
    output logic                     rdy,
    output logic signed [HEAD_W-1:0] heading,
    output logic [7:0]               LED
);
    typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

    state_t                    state_q, state_d;
    logic [CAL_SMPLS_LOG2:0]   cnt_q, cnt_d;
    logic signed [INT_W-1:0]   acc_q, acc_d, fus;
    logic signed [18:0]        off_q, off_d, comp_q, comp_d, scaled;
    logic signed [25:0]        prod;
    logic                      vld_d1_q, vld_d2_q;

    assign cal_done = (state_q == CAL) && (cnt_q == {1'b1, {CAL_SMPLS_LOG2{1'b0}}});
    assign cal_busy = state_q == CAL;
    assign rdy      = vld_d2_q;
    assign heading  = acc_q[INT_W-1 -: HEAD_W];
    assign LED      = heading[HEAD_W-1 -: 8];
    assign prod     = 26'(comp_q) * 26'(SCALE_NUM);
    assign scaled   = 19'(prod >>> SCALE_SHIFT);

`ifdef GUARDRAIL_FUSION_EN
    assign fus = (lftIR & ~rghtIR) ? INT_W'(FUSION_MAG) :
                 (~lftIR & rghtIR) ? -INT_W'(FUSION_MAG) : '0;
`else
    logic unused_ir;
    assign unused_ir = &{1'b0, lftIR, rghtIR, FUSION_MAG[0]};
    assign fus = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        off_d   = off_q;
        comp_d  = !vld ? comp_q : (state_q == RUN) ? (19'(yaw_rt) <<< 3) - off_q : 19'(yaw_rt);
        if (strt_cal) begin
            state_d = CAL;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (cal_done) begin
            state_d = RUN;
            off_d   = acc_q[CAL_SMPLS_LOG2-3 +: 19];
            acc_d   = '0;
        end else if (state_q == RUN && zero_hdg) begin
            acc_d = '0;
        end else if (vld_d1_q && state_q == CAL) begin
            acc_d = acc_q + INT_W'(comp_q);
            cnt_d = cnt_q + {{CAL_SMPLS_LOG2{1'b0}}, 1'b1};
        end else if (vld_d1_q && state_q == RUN && moving) begin
            acc_d = acc_q + INT_W'(scaled) + fus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            off_q    <= '0;
            comp_q   <= '0;
            vld_d1_q <= 1'b0;
            vld_d2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            off_q    <= off_d;
            comp_q   <= comp_d;
            vld_d1_q <= vld;
            vld_d2_q <= vld_d1_q;
        end
    end
endmodule

// File: tb/tb_yaw_integrator.sv
// tb_yaw_integrator: table-driven cycle vectors plus hand sequences for restart, fusion, zero and reset.
module tb_yaw_integrator;
    typedef struct {
        logic        sc, zh, v;
        logic [15:0] yaw;
        logic        mv, l, r;
        logic        done, busy, rdy;
        logic [11:0] hdg;
    } vec_t;

    localparam logic [15:0] Y1 = 16'h0010;
    localparam logic [15:0] YP = 16'h4010;
    localparam logic [15:0] YN = 16'hBFF0;
`ifdef GUARDRAIL_FUSION_EN
    localparam logic [31:0] FUS_ACC = 32'd98304;
    localparam logic [31:0] FUS_HDG = 32'd3;
`else
    localparam logic [31:0] FUS_ACC = 32'd0;
    localparam logic [31:0] FUS_HDG = 32'd0;
`endif

    logic clk = 0, rst_n = 0, strt_cal = 0, zero_hdg = 0, vld = 0, moving = 1, lftIR = 0, rghtIR = 0;
    logic [15:0] yaw_rt = '0;
    logic        cal_done, cal_busy, rdy;
    logic [11:0] heading;
    logic [7:0]  LED;
    int          nchk = 0, nerr = 0, done_cnt = 0;
    vec_t        tbl[$];

    always #5 clk = ~clk;

    yaw_integrator #(.CAL_SMPLS_LOG2(3)) dut (
        .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .zero_hdg(zero_hdg), .vld(vld),
        .yaw_rt(yaw_rt), .moving(moving), .lftIR(lftIR), .rghtIR(rghtIR),
        .cal_done(cal_done), .cal_busy(cal_busy), .rdy(rdy), .heading(heading), .LED(LED)
    );

    task automatic step(input logic sc, zh, v, input logic [15:0] y, input logic mv, l, r);
        strt_cal = sc; zero_hdg = zh; vld = v; yaw_rt = y; moving = mv; lftIR = l; rghtIR = r;
        @(posedge clk);
        #1;
        done_cnt += int'(cal_done);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        tbl.push_back('{1, 0, 0, 16'h0, 1, 0, 0, 0, 1, 0, 12'h000});
        for (int i = 1; i <= 8; i++) tbl.push_back('{0, 0, 1, Y1, 1, 0, 0, 0, 1, logic'(i > 1), 12'h000});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 1, 1, 1, 12'h000});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 12'h000});
        tbl.push_back('{0, 0, 1, YP,    1, 0, 0, 0, 0, 0, 12'h000});
        tbl.push_back('{0, 0, 1, YP,    1, 0, 0, 0, 0, 1, 12'h003});
        tbl.push_back('{0, 0, 1, YP,    1, 0, 0, 0, 0, 1, 12'h007});
        tbl.push_back('{0, 0, 1, YP,    1, 0, 0, 0, 0, 1, 12'h00B});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 1, 12'h00F});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 12'h00F});
        tbl.push_back('{0, 0, 1, YP,    0, 0, 0, 0, 0, 0, 12'h00F});
        tbl.push_back('{0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 1, 12'h00F});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 12'h00F});
        tbl.push_back('{0, 0, 1, YN,    1, 0, 0, 0, 0, 0, 12'h00F});
        tbl.push_back('{0, 0, 1, YN,    1, 0, 0, 0, 0, 1, 12'h00B});
        tbl.push_back('{0, 0, 1, YN,    1, 0, 0, 0, 0, 1, 12'h007});
        tbl.push_back('{0, 0, 1, YN,    1, 0, 0, 0, 0, 1, 12'h003});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 1, 12'hFFF});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 12'hFFF});
        tbl.push_back('{0, 1, 0, 16'h0, 1, 0, 0, 0, 0, 0, 12'h000});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 12'h000});
        tbl.push_back('{0, 0, 1, YP,    1, 0, 0, 0, 0, 0, 12'h000});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 1, 12'h003});
        tbl.push_back('{0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 12'h003});

        #3;
        chk("reset cal_done", cal_done, 0);
        chk("reset cal_busy", cal_busy, 0);
        chk("reset rdy", rdy, 0);
        chk("reset heading", heading, 0);
        chk("reset LED", LED, 0);
        @(posedge clk);
        #1 rst_n = 1;

        foreach (tbl[i]) begin
            step(tbl[i].sc, tbl[i].zh, tbl[i].v, tbl[i].yaw, tbl[i].mv, tbl[i].l, tbl[i].r);
            chk($sformatf("v%0d cal_done", i), cal_done, tbl[i].done);
            chk($sformatf("v%0d cal_busy", i), cal_busy, tbl[i].busy);
            chk($sformatf("v%0d rdy", i), rdy, tbl[i].rdy);
            chk($sformatf("v%0d heading", i), heading, tbl[i].hdg);
            chk($sformatf("v%0d LED", i), LED, tbl[i].hdg[11:4]);
        end
        chk("cal off", dut.off_q, 128);

        // zero_hdg on the same cycle as a stage-2 update drops that sample
        step(0, 0, 1, YP, 1, 0, 0);
        step(0, 1, 0, 16'h0, 1, 0, 0);
        chk("zero concurrent heading", heading, 0);
        step(0, 0, 0, 16'h0, 1, 0, 0);
        chk("zero concurrent acc", dut.acc_q, 0);

        for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0110, 1, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0, 0);
        chk("integ acc", dut.acc_q, 7936);
        chk("integ heading", heading, 0);
        chk("integ off kept", dut.off_q, 128);

        done_cnt = 0;
        step(1, 0, 0, 16'h0, 1, 0, 0);
        chk("restart busy", cal_busy, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, Y1, 1, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0, 0);
        chk("restart cnt5", dut.cnt_q, 5);
        step(1, 0, 0, 16'h0, 1, 0, 0);
        chk("restart cnt0", dut.cnt_q, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0020, 1, 0, 0);
        for (int k = 0; k < 10 && cal_busy; k++) step(0, 0, 0, 16'h0, 1, 0, 0);
        chk("restart timeout busy", cal_busy, 0);
        chk("restart done pulses", done_cnt, 1);
        chk("restart off", dut.off_q, 256);
        chk("restart heading", heading, 0);

        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0020, 1, 1, 0);
        step(0, 0, 0, 16'h0, 1, 1, 0);
        step(0, 0, 0, 16'h0, 1, 1, 0);
        chk("fusion left acc", dut.acc_q, FUS_ACC);
        chk("fusion left heading", heading, FUS_HDG);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0020, 1, 0, 1);
        step(0, 0, 0, 16'h0, 1, 0, 1);
        step(0, 0, 0, 16'h0, 1, 0, 1);
        chk("fusion right acc", dut.acc_q, 0);

        step(0, 0, 1, 16'h4020, 1, 0, 0);
        step(0, 0, 1, 16'h4020, 1, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0, 0);
        chk("prereset heading", heading, 7);
        chk("prereset rdy", rdy, 1);
        #2 rst_n = 0;
        #1;
        chk("async reset heading", heading, 0);
        chk("async reset rdy", rdy, 0);
        chk("async reset busy", cal_busy, 0);
        chk("async reset LED", LED, 0);
        chk("async reset off", dut.off_q, 0);
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 3; i++) step(0, 0, 1, YP, 1, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0, 0);
        chk("idle ignores vld heading", heading, 0);
        chk("idle ignores vld acc", dut.acc_q, 0);
        chk("idle busy", cal_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/yaw_integrator.md
# yaw_integrator

Parametrised gyro yaw integrator that calibrates a zero-rate offset, then integrates offset-compensated, scaled yaw rate into a wrapping heading. It sits between `inert_intf` (raw `yaw_rt` plus `vld` pulse) and the navigation/PID logic that consumes `heading`. Compared with the previous integrator it adds:
- parametric calibration length, scale factor, widths and fusion magnitude;
- a `zero_hdg` re-zero command that does not recalibrate;
- a `cal_busy` status output;
- compile-time optional guardrail fusion.

## Interface
- `CAL_SMPLS_LOG2`, default 11: calibration averages 2^N samples; legal range 3..16.
- `SCALE_NUM`, default 31: rate scale numerator; unsigned, 1..63.
- `SCALE_SHIFT`, default 5: rate scale denominator is 2^SCALE_SHIFT.
- `INT_W`, default 27: integrator/accumulator width; must be at least 19+CAL_SMPLS_LOG2−3 and at least 20.
- `HEAD_W`, default 12: heading width; must not exceed INT_W−8.
- `FUSION_MAG`, default 12288: per-sample guardrail correction, in compensated-rate units.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `strt_cal`, in, 1: start or restart calibration (level sampled each cycle).
- `zero_hdg`, in, 1: clear the heading integrator while in RUN.
- `vld`, in, 1: one-cycle pulse, new `yaw_rt` valid.
- `yaw_rt`, in, 16 signed: raw gyro rate.
- `moving`, in, 1: integrate in RUN only when high.
- `lftIR`, `rghtIR`, in, 1 each: guardrail sensors.
- `cal_done`, out, 1: one-cycle pulse when calibration completes.
- `cal_busy`, out, 1: high while in CAL.
- `rdy`, out, 1: `vld` delayed by 2 cycles.
- `heading`, out, HEAD_W signed: `int[INT_W-1 -: HEAD_W]`.
- `LED`, out, 8: `heading[HEAD_W-1 -: 8]`.

## Operation
- **States:** IDLE, CAL, RUN.
  - IDLE → CAL on `strt_cal`.
  - CAL → RUN when the sample count equals 2^CAL_SMPLS_LOG2.
  - RUN → CAL on `strt_cal`.
  - `strt_cal` in CAL restarts calibration.
  - Entering CAL clears the sample counter and the accumulator/integrator on that edge.
- **Stage 1**, on the `vld` cycle:
  - In RUN, register `comp = (yaw_rt<<<3) − off`, 19 bits.
  - Otherwise, register `comp` = `yaw_rt` sign-extended to 19 bits.
- **Stage 2**, on the `vld_d1` cycle:
  - In CAL: `acc += sext(comp)`, sample counter +1.
  - In RUN with `moving`: `int += sext(scaled) + sext(fus)`, where `scaled = (comp*SCALE_NUM)>>>SCALE_SHIFT` (arithmetic, truncated to 19 bits).
  - Accumulator and integrator are the same INT_W register.
- **Calibration completion:** in the cycle where count == 2^N:
  - `cal_done` = 1;
  - `off <= acc[CAL_SMPLS_LOG2-3 +: 19]`;
  - integrator is cleared;
  - next state is RUN.
- **Fusion** (`fus`): +FUSION_MAG when `lftIR & ~rghtIR`; −FUSION_MAG when `~lftIR & rghtIR`; 0 otherwise; 0 outside RUN.
- **Wrap-around:** the integrator wraps modulo 2^INT_W (no saturation), so `heading` wraps through ±180°.
- **Priority, highest first:** `rst_n`, `strt_cal`, cal completion, `zero_hdg`, integrate.
  - `zero_hdg` outside RUN is ignored.
  - `zero_hdg` coincident with a stage-2 update clears the integrator; that sample is dropped.
- A `vld` arriving during the completion cycle enters stage 1 with RUN semantics only if its stage-2 update lands in RUN. Its stage-1 value is captured with the pre-transition mode and is accepted as is (at most one sample is mis-compensated).

## Timing
- **Reset values:** state IDLE; `cal_done` 0; `cal_busy` 0; `rdy` 0; `heading` 0; `LED` 0; `off` 0; counter 0; pipeline flops 0.
- `strt_cal` at cycle t gives `cal_busy` = 1 from t+1.
- **Heading latency:** `vld` at t → stage 1 at edge t+1 → integrator at edge t+2. `heading` is updated in cycle t+2, coincident with `rdy`.
- `cal_done` is combinational from state and counter. It is high exactly one cycle, the cycle after the Nth stage-2 count edge, and `cal_busy` drops the following cycle.
- Back-to-back `vld` on consecutive cycles is supported; throughput is one sample per clock.
- **Reset mid-operation:** every register returns to its reset value asynchronously and the offset is lost. Recalibration is required.

## Configuration
- `GUARDRAIL_FUSION_EN` defined: fusion active as described.
- `GUARDRAIL_FUSION_EN` undefined: `fus` is tied to 0. `lftIR`/`rghtIR` remain ports but are ignored, and the FUSION_MAG logic is not synthesised.

## Test plan
Default parameters are used except CAL_SMPLS_LOG2=3, with `moving`=1.
- **Calibration:** `strt_cal` then 8 `vld` with `yaw_rt`=0x0010 → `off`=128, one `cal_done` pulse, state RUN, `heading`=0.
- **Integration:** in RUN, 4 `vld` with `yaw_rt`=0x0110 → each adds 2048*31>>5 = 1984; integrator 7936; `rdy` 2 cycles after each `vld`.
- **Fusion:** macro defined, `lftIR`=1, `rghtIR`=0, 8 `vld` with `yaw_rt`=0x0010 → integrator 98304, `heading`=3. With the macro undefined, `heading` stays 0.
- **`moving`/`zero_hdg`:**
  - `moving`=0 with `vld` → no change.
  - `zero_hdg` pulse → `heading` 0 next cycle; `off` unchanged.
  - `zero_hdg` concurrent with a stage-2 sample → result 0.
- **Restart:** `strt_cal` after 5 calibration samples → counter restarts. Completion comes 8 samples later, and `off` reflects only those 8.
- **Reset:** `rst_n` low mid-RUN → all outputs 0 immediately, state IDLE. `vld` is then ignored until `strt_cal`.
